// File: rtl/blackparrot_fpga_host_io_out.sv
// AXI4 slave for BP I/O-out traffic: each access becomes a 5-flit NBF packet
// to the host; reads wait for two 32b response flits before answering on R.
module blackparrot_fpga_host_io_out #(
    parameter int S_AXI_ADDR_WIDTH   = 64,
    parameter int S_AXI_DATA_WIDTH   = 64,
    parameter int S_AXI_ID_WIDTH     = 4,
    parameter int fifo_data_width_p  = 32,
    parameter int nbf_opcode_width_p = 8
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [2:0]                    s_axi_awsize,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,

    input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,

    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,

    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [2:0]                    s_axi_arsize,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,

    output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,

    output logic                          io_v_o,
    output logic [fifo_data_width_p-1:0]  io_data_o,
    input  logic                          io_yumi_i,

    input  logic                          io_resp_v_i,
    input  logic [fifo_data_width_p-1:0]  io_resp_data_i,
    output logic                          io_resp_ready_and_o
);

    typedef enum logic [2:0] {
        e_ready,
        e_send,
        e_bresp,
        e_rdata,
        e_rresp
    } state_e;

    localparam logic [nbf_opcode_width_p-1:0] rd_op_lp = 'h10;
    localparam int op_pad_lp = nbf_opcode_width_p - 3;
    localparam int flit_pad_lp = fifo_data_width_p - nbf_opcode_width_p;

    state_e state_q, state_d;

    logic                          rr_rd_pri_q, rr_rd_pri_d;
    logic                          rd_q, rd_d;
    logic [S_AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [S_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [S_AXI_DATA_WIDTH-1:0]   data_q, data_d;
    logic [nbf_opcode_width_p-1:0] op_q, op_d;
    logic [2:0]                    cnt_q, cnt_d;
    logic [S_AXI_DATA_WIDTH-1:0]   resp_q, resp_d;
    logic                          rcnt_q, rcnt_d;

    logic wr_elig, rd_elig;
    logic grant_w, grant_r;
    logic last_flit;
    logic unused_w;

    assign unused_w = ^{s_axi_wstrb, s_axi_wlast};

    // Both eligible: rr flag picks; it flips on every grant
    assign wr_elig = s_axi_awvalid & s_axi_wvalid;
    assign rd_elig = s_axi_arvalid;
    assign grant_w = (state_q == e_ready) & wr_elig
                   & (~rd_elig | ~rr_rd_pri_q);
    assign grant_r = (state_q == e_ready) & rd_elig & ~grant_w;
    assign last_flit = io_yumi_i & (cnt_q == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= e_ready;
            rr_rd_pri_q <= 1'b0;
            rd_q        <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            resp_q      <= '0;
            rcnt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_rd_pri_q <= rr_rd_pri_d;
            rd_q        <= rd_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            rcnt_q      <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_ready: begin
                if (grant_w | grant_r)
                    state_d = e_send;
            end
            e_send: begin
                if (last_flit)
                    state_d = rd_q ? e_rdata : e_bresp;
            end
            e_bresp: begin
                if (s_axi_bready)
                    state_d = e_ready;
            end
            e_rdata: begin
                if (io_resp_v_i & rcnt_q)
                    state_d = e_rresp;
            end
            e_rresp: begin
                if (s_axi_rready)
                    state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase
    end

    // Packet capture, flit counter and read-response assembly
    always_comb begin
        rr_rd_pri_d = rr_rd_pri_q;
        rd_d        = rd_q;
        id_d        = id_q;
        addr_d      = addr_q;
        data_d      = data_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        rcnt_d      = rcnt_q;
        if (grant_w) begin
            rr_rd_pri_d = ~rr_rd_pri_q;
            rd_d        = 1'b0;
            id_d        = s_axi_awid;
            addr_d      = s_axi_awaddr;
            data_d      = s_axi_wdata >> {s_axi_awaddr[2:0], 3'b000};
            op_d        = {{op_pad_lp{1'b0}}, s_axi_awsize};
            cnt_d       = '0;
            rcnt_d      = 1'b0;
        end else if (grant_r) begin
            rr_rd_pri_d = ~rr_rd_pri_q;
            rd_d        = 1'b1;
            id_d        = s_axi_arid;
            addr_d      = s_axi_araddr;
            data_d      = '0;
            op_d        = {{op_pad_lp{1'b0}}, s_axi_arsize} | rd_op_lp;
            cnt_d       = '0;
            rcnt_d      = 1'b0;
        end
        if ((state_q == e_send) && io_yumi_i)
            cnt_d = cnt_q + 3'd1;
        if ((state_q == e_rdata) && io_resp_v_i) begin
            if (rcnt_q)
                resp_d[63:32] = io_resp_data_i;
            else
                resp_d[31:0] = io_resp_data_i;
            rcnt_d = ~rcnt_q;
        end
    end

    always_comb begin
        s_axi_awready       = grant_w;
        s_axi_wready        = grant_w;
        s_axi_arready       = grant_r;
        s_axi_bid           = id_q;
        s_axi_bresp         = 2'b00;
        s_axi_bvalid        = (state_q == e_bresp);
        s_axi_rdata         = resp_q << {addr_q[2:0], 3'b000};
        s_axi_rid           = id_q;
        s_axi_rresp         = 2'b00;
        s_axi_rvalid        = (state_q == e_rresp);
        s_axi_rlast         = (state_q == e_rresp);
        io_v_o              = (state_q == e_send);
        io_resp_ready_and_o = (state_q == e_rdata);
        io_data_o           = '0;
        unique case (cnt_q)
            3'd0:    io_data_o = data_q[31:0];
            3'd1:    io_data_o = data_q[63:32];
            3'd2:    io_data_o = addr_q[31:0];
            3'd3:    io_data_o = addr_q[63:32];
            3'd4:    io_data_o = {{flit_pad_lp{1'b0}}, op_q};
            default: io_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_blackparrot_fpga_host_io_out.sv
// Bench for blackparrot_fpga_host_io_out: table vectors, corner
// sequences and random transactions against a packet-level model.
module tb_blackparrot_fpga_host_io_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] s_axi_awaddr;
    logic [3:0]  s_axi_awid;
    logic [2:0]  s_axi_awsize;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [63:0] s_axi_araddr;
    logic [3:0]  s_axi_arid;
    logic [2:0]  s_axi_arsize;
    logic        s_axi_arvalid, s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [3:0]  s_axi_rid;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        io_v_o;
    logic [31:0] io_data_o;
    logic        io_yumi_i;
    logic        io_resp_v_i;
    logic [31:0] io_resp_data_i;
    logic        io_resp_ready_and_o;

    always #5 clk = ~clk;

    blackparrot_fpga_host_io_out dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid),
        .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid),
        .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .io_v_o(io_v_o), .io_data_o(io_data_o), .io_yumi_i(io_yumi_i),
        .io_resp_v_i(io_resp_v_i), .io_resp_data_i(io_resp_data_i),
        .io_resp_ready_and_o(io_resp_ready_and_o)
    );

    typedef struct {
        bit               rd;
        logic [63:0]      addr;
        logic [3:0]       id;
        logic [2:0]       size;
        logic [63:0]      wdata;
        logic [63:0]      resp;
        logic [4:0][31:0] flits;
        logic [63:0]      rdata;
        int               mode;
        int               hold;
        bit               stray;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Packet as the host should see it, from the transaction alone
    function automatic logic [4:0][31:0] model_flits(
        input bit rd, input logic [63:0] addr,
        input logic [2:0] size, input logic [63:0] wdata);
        logic [4:0][31:0] f;
        logic [63:0] d;
        int byte_off;
        byte_off = int'(addr % 64'd8);
        d = rd ? 64'd0 : (wdata / (64'd1 << (8 * byte_off)));
        f[0] = d[31:0];
        f[1] = d[63:32];
        f[2] = addr[31:0];
        f[3] = addr[63:32];
        f[4] = rd ? (32'h10 + 32'(size)) : 32'(size);
        return f;
    endfunction

    function automatic logic [63:0] model_rdata(
        input logic [63:0] addr, input logic [63:0] resp);
        int byte_off;
        byte_off = int'(addr % 64'd8);
        return resp * (64'd1 << (8 * byte_off));
    endfunction

    task automatic idle_inputs();
        s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awsize = '0;
        s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '1;
        s_axi_wlast = 1; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_araddr = '0; s_axi_arid = '0; s_axi_arsize = '0;
        s_axi_arvalid = 0; s_axi_rready = 0; io_yumi_i = 0;
        io_resp_v_i = 0; io_resp_data_i = '0;
    endtask

    task automatic set_req(input bit rd, input logic [63:0] addr,
                           input logic [3:0] id, input logic [2:0] size,
                           input logic [63:0] wdata);
        if (rd) begin
            s_axi_araddr = addr; s_axi_arid = id;
            s_axi_arsize = size; s_axi_arvalid = 1;
        end else begin
            s_axi_awaddr = addr; s_axi_awid = id; s_axi_awsize = size;
            s_axi_wdata = wdata; s_axi_awvalid = 1; s_axi_wvalid = 1;
        end
    endtask

    task automatic issue(input bit rd, input logic [63:0] addr,
                         input logic [3:0] id, input logic [2:0] size,
                         input logic [63:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        set_req(rd, addr, id, size, wdata);
        #1;
        while (!(s_axi_awready | s_axi_arready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk(rd ? "ar_grant" : "aw_grant",
            {s_axi_awready, s_axi_wready, s_axi_arready},
            rd ? 3'b001 : 3'b110);
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    endtask

    // mode 0: yumi always, 1: toggling, 2: random
    task automatic send_flits(input logic [4:0][31:0] exp, input int mode,
                              input int nflits, input bit stray);
        int k, cyc;
        bit y;
        k = 0; cyc = 0;
        while (k < nflits && cyc < 200) begin
            @(negedge clk);
            if (mode == 0) y = 1;
            else if (mode == 1) y = (cyc % 2 == 0);
            else y = ($urandom_range(0, 1) == 1);
            io_yumi_i = y;
            io_resp_v_i = stray;
            io_resp_data_i = 32'hBAD0_0000 + 32'(cyc);
            #1;
            chk("io_v", io_v_o, 1);
            chk($sformatf("flit%0d", k), io_data_o, exp[k]);
            chk("axi_ready_idle",
                {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
            if (stray) chk("stray_resp_ready", io_resp_ready_and_o, 0);
            if (y) k++;
            cyc++;
        end
        if (k < nflits) chk("flit_timeout", 1, 0);
        if (mode == 0 && nflits == 5) chk("flit_cycles", cyc, 5);
        @(posedge clk); #1;
        io_yumi_i = 0; io_resp_v_i = 0;
    endtask

    task automatic serve_b(input logic [3:0] id, input int hold);
        @(negedge clk); #1;
        chk("bvalid", s_axi_bvalid, 1);
        chk("bid", s_axi_bid, id);
        chk("bresp", s_axi_bresp, 2'b00);
        chk("io_v_after_w", io_v_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("bvalid_held", s_axi_bvalid, 1);
        end
        s_axi_bready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0;
        @(negedge clk); #1;
        chk("bvalid_clear", s_axi_bvalid, 0);
    endtask

    task automatic serve_r(input logic [63:0] resp, input logic [63:0] rdata,
                           input logic [3:0] id, input int hold);
        int n;
        for (int f = 0; f < 2; f++) begin
            for (int g = 0; g < hold; g++) begin
                @(negedge clk); #1;
                chk("rvalid_early", s_axi_rvalid, 0);
            end
            @(negedge clk);
            io_resp_v_i = 1;
            io_resp_data_i = (f == 0) ? resp[31:0] : resp[63:32];
            #1;
            n = 0;
            while (!io_resp_ready_and_o && n < 20) begin
                @(negedge clk); #1; n++;
            end
            chk($sformatf("resp_ready%0d", f), io_resp_ready_and_o, 1);
            @(posedge clk); #1;
            io_resp_v_i = 0;
        end
        @(negedge clk); #1;
        chk("rvalid", s_axi_rvalid, 1);
        chk("rdata", s_axi_rdata, rdata);
        chk("rid", s_axi_rid, id);
        chk("rresp_last", {s_axi_rresp, s_axi_rlast}, 3'b001);
        chk("resp_ready_off", io_resp_ready_and_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("rvalid_held", s_axi_rvalid, 1);
        end
        s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_rready = 0;
        @(negedge clk); #1;
        chk("rvalid_clear", s_axi_rvalid, 0);
    endtask

    task automatic run_txn(input vec_t v);
        issue(v.rd, v.addr, v.id, v.size, v.wdata);
        send_flits(v.flits, v.mode, 5, v.stray);
        if (v.rd) serve_r(v.resp, v.rdata, v.id, v.hold);
        else serve_b(v.id, v.hold);
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outs",
            {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
             s_axi_rvalid, io_v_o, io_resp_ready_and_o}, 7'd0);
        reset = 0;
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        tbl[0] = '{0, 64'h0010_0000, 4'h5, 3'd3, 64'hDEADBEEF_CAFEF00D, 0,
                   {32'h3, 32'h0, 32'h0010_0000, 32'hDEADBEEF, 32'hCAFEF00D},
                   0, 0, 0, 0};
        tbl[1] = '{0, 64'h0010_0004, 4'h6, 3'd2, 64'h12345678_00000000, 0,
                   {32'h2, 32'h0, 32'h0010_0004, 32'h0, 32'h12345678},
                   0, 1, 1, 0};
        tbl[2] = '{1, 64'h0020_0004, 4'h9, 3'd2, 0, 64'h00000000_AAAA5555,
                   {32'h12, 32'h0, 32'h0020_0004, 32'h0, 32'h0},
                   64'hAAAA5555_00000000, 0, 0, 0};
        tbl[3] = '{0, 64'h3, 4'hA, 3'd0, 64'h00000000_AB000000, 0,
                   {32'h0, 32'h0, 32'h3, 32'h0, 32'hAB},
                   0, 0, 0, 1};
        tbl[4] = '{1, 64'h8000_0001_0000_0007, 4'hF, 3'd0, 0, 64'hCD,
                   {32'h10, 32'h8000_0001, 32'h7, 32'h0, 32'h0},
                   64'hCD00_0000_0000_0000, 1, 2, 0};
        tbl[5] = '{0, 64'h0000_0040_0000_0018, 4'h1, 3'd1, 64'h1111_2222_3333_BEEF, 0,
                   {32'h1, 32'h40, 32'h18, 32'h1111_2222, 32'h3333_BEEF},
                   0, 2, 0, 1};

        do_reset();
        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Simultaneous write and read after reset: write wins, read follows
        do_reset();
        @(negedge clk);
        set_req(0, 64'h0000_1000, 4'h3, 3'd3, 64'h0102_0304_0506_0708);
        set_req(1, 64'h0000_2002, 4'hC, 3'd1, 0);
        #1;
        chk("arb_first", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b110);
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        send_flits(model_flits(0, 64'h0000_1000, 3'd3, 64'h0102_0304_0506_0708),
                   1, 5, 0);
        serve_b(4'h3, 3);
        chk("arb_second", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b001);
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        send_flits(model_flits(1, 64'h0000_2002, 3'd1, 0), 2, 5, 0);
        serve_r(64'h0000_0000_0000_BEEF, 64'h0000_0000_BEEF_0000, 4'hC, 1);

        // Reset in the middle of a write packet
        issue(0, 64'h0055_0000, 4'h7, 3'd3, 64'hFEED_FACE_0BAD_F00D);
        send_flits(model_flits(0, 64'h0055_0000, 3'd3, 64'hFEED_FACE_0BAD_F00D),
                   0, 3, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk); #1;
        chk("rst_mid_io_v", io_v_o, 0);
        reset = 0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_mid_no_b", {s_axi_bvalid, io_v_o}, 2'b00);
        end
        run_txn(tbl[0]);

        for (int i = 0; i < 40; i++) begin
            v.rd    = ($urandom_range(0, 1) == 1);
            v.addr  = {$urandom, $urandom};
            v.id    = 4'($urandom);
            v.size  = 3'($urandom_range(0, 3));
            v.wdata = {$urandom, $urandom};
            v.resp  = {$urandom, $urandom};
            v.flits = model_flits(v.rd, v.addr, v.size, v.wdata);
            v.rdata = model_rdata(v.addr, v.resp);
            v.mode  = 2;
            v.hold  = $urandom_range(0, 2);
            v.stray = !v.rd && ($urandom_range(0, 3) == 0);
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
